// File: rtl/toggle_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_gen_pkg
//  Description : Shared constants for the toggle-enable generator:
//                default widths and the 2-bit FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package toggle_gen_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int BURST_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

endpackage : toggle_gen_pkg
`default_nettype wire

// File: rtl/tgen_period_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tgen_period_cnt
//  Description : Reloading down-counter that paces the toggle pulses.
//                'load' forces load_val in; while 'en' is high the counter
//                decrements and, on reaching zero, reloads load_val on the
//                following edge. 'zero' flags the count value 0.
//  Ports       : clk, reset (async, active-low), load, load_val, en -> zero
//  Revision    : 1.0  initial release
// ============================================================================
module tgen_period_cnt
    import toggle_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= (r_cnt == '0) ? load_val : r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule : tgen_period_cnt
`default_nettype wire

// File: rtl/toggle_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_enable_gen
//  Description : Drives the single-cycle toggle-enable 't' into the T flop
//                stage. Pulses are spaced by a programmable period, issued
//                as a finite burst or continuously, and 'tq' mirrors the
//                downstream flop level (power-on value 1).
//  Ports       : clk, reset (async, active-low), start, stop, period,
//                burst_len -> t, tq, busy, done, pulse_cnt
//  Revision    : 1.0  initial release
// ============================================================================
module toggle_enable_gen
    import toggle_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               t,
    output logic               tq,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_period_m1;     // latched effective period minus one
    logic [BURST_W-1:0] r_burst;
    logic               r_t;
    logic               r_tq;
    logic               r_busy;
    logic               r_done;
    logic [BURST_W-1:0] r_pulse_cnt;

    logic               w_t_next;
    logic [BURST_W-1:0] w_pulse_cnt_next;
    logic               w_start_run;
    logic [CNT_W-1:0]   w_in_period_m1;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_cnt_en;
    logic               w_cnt_zero;
    logic               w_burst_hit;

    assign w_start_run    = (r_state == c_ST_IDLE) && start && !stop;
    // A period of 0 behaves as 1, i.e. a reload value of 0.
    assign w_in_period_m1 = (period == '0) ? '0 : period - CNT_W'(1);
    // The live input only matters on the start edge; afterwards the latched
    // copy keeps mid-run period changes from having any effect.
    assign w_load_val     = w_start_run ? w_in_period_m1 : r_period_m1;
    assign w_cnt_en       = (r_state == c_ST_RUN);
    // Finite burst already delivered its last pulse.
    assign w_burst_hit    = (r_burst != '0) && (r_pulse_cnt == r_burst);

    tgen_period_cnt #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_start_run),
        .load_val (w_load_val),
        .en       (w_cnt_en),
        .zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_next     = r_state;
        w_t_next         = 1'b0;
        w_pulse_cnt_next = r_pulse_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_run) begin
                    w_state_next     = c_ST_RUN;
                    w_pulse_cnt_next = '0;
                end
            end
            c_ST_RUN: begin
                // stop outranks both burst completion and a due pulse
                if (stop) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_burst_hit) begin
                    w_state_next = c_ST_DONE;
                end else if (w_cnt_zero) begin
                    w_t_next         = 1'b1;
                    w_pulse_cnt_next = r_pulse_cnt + BURST_W'(1);
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_period_m1 <= '0;
            r_burst     <= '0;
            r_t         <= 1'b0;
            r_tq        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_t         <= w_t_next;
            r_tq        <= r_tq ^ w_t_next;
            r_busy      <= (w_state_next == c_ST_RUN);
            r_done      <= (w_state_next == c_ST_DONE);
            r_pulse_cnt <= w_pulse_cnt_next;
            if (w_start_run) begin
                r_period_m1 <= w_in_period_m1;
                r_burst     <= burst_len;
            end
        end
    end

    assign t         = r_t;
    assign tq        = r_tq;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pulse_cnt = r_pulse_cnt;

endmodule : toggle_enable_gen
`default_nettype wire

// File: tb/tb_toggle_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toggle_enable_gen
//  Description : Directed self-checking bench for toggle_enable_gen.
//                Observed vector is {t, tq, busy, done, pulse_cnt[7:0]}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_toggle_enable_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [7:0] period;
    logic [7:0] burst_len;
    wire        t;
    wire        tq;
    wire        busy;
    wire        done;
    wire  [7:0] pulse_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_enable_gen #(
        .CNT_W   (8),
        .BURST_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .burst_len (burst_len),
        .t         (t),
        .tq        (tq),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pk(input bit et, input bit etq, input bit ebusy,
                                        input bit edone, input int epc);
        return {et, etq, ebusy, edone, 8'(epc)};
    endfunction

    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {t, tq, busy, done, pulse_cnt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed {t,tq,busy,done,pc}=%03h expected %03h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bit tqm;
        int pcm;
        bit et;

        reset = 1'b0; start = 1'b0; stop = 1'b0; period = 8'd0; burst_len = 8'd0;

        // 1: reset values, then idle for 20 cycles
        tick();
        chk("t1_in_reset", pk(0, 1, 0, 0, 0));
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("t1_idle_c%0d", c), pk(0, 1, 0, 0, 0));
        end

        // 2: period 4, burst 3 -> t at 4,8,12, done at 13
        period = 8'd4; burst_len = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_c0", pk(0, 1, 1, 0, 0));
        tqm = 1'b1; pcm = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            et = (c == 4 || c == 8 || c == 12);
            if (et) begin tqm = !tqm; pcm++; end
            chk($sformatf("t2_c%0d", c), pk(et, tqm, c <= 12, c == 13, pcm));
        end
        chk("t2_final", pk(0, 0, 0, 0, 3));

        // 3: period 0 treated as 1, burst 5 -> t at 1..5, done at 6
        do_reset();
        period = 8'd0; burst_len = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tqm = 1'b1; pcm = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            et = (c >= 1 && c <= 5);
            if (et) begin tqm = !tqm; pcm++; end
            chk($sformatf("t3_c%0d", c), pk(et, tqm, c <= 5, c == 6, pcm));
        end
        chk("t3_final", pk(0, 0, 0, 0, 5));

        // 4: period 3, continuous, stop sampled at edge 9 while cnt==0
        do_reset();
        period = 8'd3; burst_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tqm = 1'b1; pcm = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            et = (c == 3 || c == 6);
            if (et) begin tqm = !tqm; pcm++; end
            chk($sformatf("t4_c%0d", c), pk(et, tqm, 1, 0, pcm));
            if (c == 8) stop = 1'b1;
        end
        tick();
        stop = 1'b0;
        chk("t4_c9_stopped", pk(0, 1, 0, 0, 2));
        tick();
        chk("t4_c10_idle", pk(0, 1, 0, 0, 2));

        // 5a: start and stop together in IDLE
        do_reset();
        period = 8'd2; burst_len = 8'd2; start = 1'b1; stop = 1'b1;
        tick();
        chk("t5a_c0", pk(0, 1, 0, 0, 0));
        start = 1'b0; stop = 1'b0;
        tick();
        chk("t5a_c1", pk(0, 1, 0, 0, 0));

        // 5b: period 5 continuous, restart attempt with period 2 mid-run
        period = 8'd5; burst_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tqm = 1'b1; pcm = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            et = (c % 5 == 0);
            if (et) begin tqm = !tqm; pcm++; end
            chk($sformatf("t5b_c%0d", c), pk(et, tqm, 1, 0, pcm));
            if (c == 2) begin period = 8'd2; burst_len = 8'd1; start = 1'b1; end
            if (c == 3) start = 1'b0;
            if (c == 16) stop = 1'b1;
        end
        tick();
        stop = 1'b0;
        chk("t5b_stopped", pk(0, 0, 0, 0, 3));

        // 6: period 5, burst 4, async reset at cycle 7
        do_reset();
        period = 8'd5; burst_len = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tqm = 1'b1; pcm = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            et = (c == 5);
            if (et) begin tqm = !tqm; pcm++; end
            chk($sformatf("t6_c%0d", c), pk(et, tqm, 1, 0, pcm));
        end
        #2 reset = 1'b0;
        #1 chk("t6_async_reset", pk(0, 1, 0, 0, 0));
        tick();
        tick();
        chk("t6_held_reset", pk(0, 1, 0, 0, 0));
        reset = 1'b1;
        tick();
        chk("t6_idle_after", pk(0, 1, 0, 0, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_restart_c0", pk(0, 1, 1, 0, 0));
        tqm = 1'b1; pcm = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            et = (c == 5);
            if (et) begin tqm = !tqm; pcm++; end
            chk($sformatf("t6_restart_c%0d", c), pk(et, tqm, 1, 0, pcm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_toggle_enable_gen
`default_nettype wire
